// File: rtl/maze_world_ctrl_if.sv
// ---------------------------------------------------------------------------
// maze_world_ctrl_if
//   Command channel between a robot controller and the maze world model.
//   Signals:
//     cmd_valid  controller -> world  command offered
//     cmd_op     controller -> world  00 move, 01 turn left, 10 turn right,
//                                     11 remove barrier ahead
//     cmd_ready  world -> controller  world can accept a command
//     done       world -> controller  one-cycle completion pulse
//     err        world -> controller  command rejected (valid with done)
//   Modports:
//     master  the robot controller
//     slave   the world model
// ---------------------------------------------------------------------------
interface maze_world_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       done;
  logic       err;

  modport master (
    output cmd_valid,
    output cmd_op,
    input  cmd_ready,
    input  done,
    input  err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    output cmd_ready,
    output done,
    output err
  );
endinterface

// File: rtl/maze_world_ctrl.sv
// ---------------------------------------------------------------------------
// maze_world_ctrl
//   World model for a robot in a ROWS x COLS maze. Holds the cell map and the
//   robot pose, executes move / turn-left / turn-right / remove-barrier
//   commands arriving over a valid/ready channel, and drives the sensors the
//   robot controller sees.
//
//   Cell codes: WALL=0, PATH=1, B3=2, B6=3, B9=4, BLACK=7 (5 and 6 are
//   passable like PATH). Headings: N=0, W=1, S=2, E=3.
//
//   Ports:
//     clock        rising-edge clock
//     reset        asynchronous, active-high
//     cmd          command channel (slave side): cmd_valid, cmd_op,
//                  cmd_ready, done, err
//     head_out     cell ahead is WALL or off-map
//     left_out     cell to the left is WALL or off-map
//     right_out    cell to the right is WALL or off-map
//     under_out    current cell is BLACK
//     barrier_out  cell ahead is on-map and B3/B6/B9
//     robo_row     current row
//     robo_col     current column
//     robo_dir     current heading
//
//   Flow: IDLE -> (EXEC) -> RESP -> IDLE. Moves and turns update the pose on
//   the accepting edge and respond in the next cycle. A remove with a barrier
//   ahead spends REMOVE_CYCLES cycles in EXEC, downgrades the barrier one
//   level on the last of them and then responds.
// ---------------------------------------------------------------------------
module maze_world_ctrl #(
  parameter int ROWS          = 10,
  parameter int COLS          = 20,
  parameter int START_ROW     = ROWS - 1,
  parameter int START_COL     = 0,
  parameter int REMOVE_CYCLES = 3,
  localparam int ROW_W        = $clog2(ROWS),
  localparam int COL_W        = $clog2(COLS)
) (
  input  logic                 clock,
  input  logic                 reset,
  maze_world_ctrl_if.slave     cmd,
  output logic                 head_out,
  output logic                 left_out,
  output logic                 right_out,
  output logic                 under_out,
  output logic                 barrier_out,
  output logic [ROW_W-1:0]     robo_row,
  output logic [COL_W-1:0]     robo_col,
  output logic [1:0]           robo_dir
);

  localparam int CNT_W = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;

  localparam logic [2:0] CELL_WALL  = 3'd0;
  localparam logic [2:0] CELL_B3    = 3'd2;
  localparam logic [2:0] CELL_B6    = 3'd3;
  localparam logic [2:0] CELL_B9    = 3'd4;
  localparam logic [2:0] CELL_BLACK = 3'd7;

  typedef enum logic [1:0] {
    OP_MOVE   = 2'd0,
    OP_LEFT   = 2'd1,
    OP_RIGHT  = 2'd2,
    OP_REMOVE = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  // A neighbouring cell; on_map=0 means the step would leave the map.
  typedef struct packed {
    logic             on_map;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } cell_ref_t;

  // Cell one step from (r, c) in heading d. Edges are detected explicitly so
  // no index ever wraps around.
  function automatic cell_ref_t neighbour(input logic [ROW_W-1:0] r,
                                          input logic [COL_W-1:0] c,
                                          input logic [1:0]       d);
    cell_ref_t n;
    n.on_map = 1'b1;
    n.row    = r;
    n.col    = c;
    case (d)
      2'd0: begin
        if (r == '0) n.on_map = 1'b0;
        else         n.row    = r - 1'b1;
      end
      2'd1: begin
        if (c == '0) n.on_map = 1'b0;
        else         n.col    = c - 1'b1;
      end
      2'd2: begin
        if (r == ROW_W'(ROWS - 1)) n.on_map = 1'b0;
        else                       n.row    = r + 1'b1;
      end
      default: begin
        if (c == COL_W'(COLS - 1)) n.on_map = 1'b0;
        else                       n.col    = c + 1'b1;
      end
    endcase
    return n;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [2:0]       cell_map [ROWS][COLS];

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q,   row_d;
  logic [COL_W-1:0] col_q,   col_d;
  logic [1:0]       dir_q,   dir_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             err_q,   err_d;

  logic             map_we;
  logic [2:0]       map_wdata;

  // ---------------------------------------------------------------------
  // Sensors: combinational from the registered pose and map
  // ---------------------------------------------------------------------
  cell_ref_t  ahead, left_n, right_n;
  logic [2:0] ahead_code, left_code, right_code, here_code;

  assign ahead   = neighbour(row_q, col_q, dir_q);
  assign left_n  = neighbour(row_q, col_q, dir_q + 2'd1);
  assign right_n = neighbour(row_q, col_q, dir_q - 2'd1);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    ahead_code = CELL_WALL;
    left_code  = CELL_WALL;
    right_code = CELL_WALL;
    if (ahead.on_map)   ahead_code = cell_map[ahead.row][ahead.col];
    if (left_n.on_map)  left_code  = cell_map[left_n.row][left_n.col];
    if (right_n.on_map) right_code = cell_map[right_n.row][right_n.col];
    here_code = cell_map[row_q][col_q];
  end

  // Off-map neighbours already read as WALL, so barrier_out needs no extra
  // on-map qualification.
  assign head_out    = (ahead_code == CELL_WALL);
  assign left_out    = (left_code  == CELL_WALL);
  assign right_out   = (right_code == CELL_WALL);
  assign under_out   = (here_code  == CELL_BLACK);
  assign barrier_out = (ahead_code == CELL_B3) || (ahead_code == CELL_B6) ||
                       (ahead_code == CELL_B9);

  assign robo_row = row_q;
  assign robo_col = col_q;
  assign robo_dir = dir_q;

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.done      = (state_q == ST_RESP);
  assign cmd.err       = (state_q == ST_RESP) && err_q;

  // ---------------------------------------------------------------------
  // Next state. The op only matters at accept: every decision is taken on
  // the accepting edge, and EXEC is entered only by a remove.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    map_we    = 1'b0;
    map_wdata = ahead_code - 3'd1;  // B9->B6->B3->PATH is a plain decrement

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          err_d   = 1'b0;
          state_d = ST_RESP;
          case (op_t'(cmd.cmd_op))
            OP_MOVE: begin
              if (head_out || barrier_out) begin
                err_d = 1'b1;
              end else begin
                row_d = ahead.row;
                col_d = ahead.col;
              end
            end
            OP_LEFT:  dir_d = dir_q + 2'd1;
            OP_RIGHT: dir_d = dir_q - 2'd1;
            default: begin
              if (barrier_out) begin
                state_d = ST_EXEC;
                cnt_d   = '0;
              end else begin
                err_d = 1'b1;
              end
            end
          endcase
        end
      end

      ST_EXEC: begin
        if (cnt_q == CNT_W'(REMOVE_CYCLES - 1)) begin
          map_we  = 1'b1;
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= ROW_W'(START_ROW);
      col_q   <= COL_W'(START_COL);
      dir_q   <= 2'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the map is deliberately left out of reset: removed barriers must
  // survive a reset, and an unreset array maps onto plain RAM. A reset during
  // EXEC returns the FSM to IDLE at once, so map_we stays low and an aborted
  // remove never writes.
  always_ff @(posedge clock) begin
    if (map_we) cell_map[ahead.row][ahead.col] <= map_wdata;
  end

endmodule

// File: tb/tb_maze_world_ctrl.sv
// ---------------------------------------------------------------------------
// tb_maze_world_ctrl
//   Directed bench for maze_world_ctrl. A transaction-level model (integer
//   map, integer pose, expected ready/done/err levels) is advanced by the
//   command driver; a negedge process compares every DUT output with it on
//   every cycle. Literal expectations pin both the model and the DUT.
// ---------------------------------------------------------------------------
module tb_maze_world_ctrl;
  localparam int ROWS          = 10;
  localparam int COLS          = 20;
  localparam int START_ROW     = 9;
  localparam int START_COL     = 0;
  localparam int REMOVE_CYCLES = 3;

  localparam logic [1:0] OP_MOVE   = 2'd0;
  localparam logic [1:0] OP_LEFT   = 2'd1;
  localparam logic [1:0] OP_RIGHT  = 2'd2;
  localparam logic [1:0] OP_REMOVE = 2'd3;

  logic       clock = 1'b0;
  logic       reset;
  logic       head_out, left_out, right_out, under_out, barrier_out;
  logic [3:0] robo_row;
  logic [4:0] robo_col;
  logic [1:0] robo_dir;

  maze_world_ctrl_if bus ();

  maze_world_ctrl #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .START_ROW     (START_ROW),
    .START_COL     (START_COL),
    .REMOVE_CYCLES (REMOVE_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd         (bus),
    .head_out    (head_out),
    .left_out    (left_out),
    .right_out   (right_out),
    .under_out   (under_out),
    .barrier_out (barrier_out),
    .robo_row    (robo_row),
    .robo_col    (robo_col),
    .robo_dir    (robo_dir)
  );

  initial forever #5 clock = ~clock;

  // ---------------------------------------------------------------------
  // Scoreboard counters and check
  // ---------------------------------------------------------------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Model
  // ---------------------------------------------------------------------
  int mm [ROWS][COLS];
  int dr [4] = '{-1, 0, 1, 0};   // N, W, S, E
  int dc [4] = '{0, -1, 0, 1};

  int m_row, m_col, m_dir;
  int m_ready, m_done, m_err;
  bit cmp_en = 1'b0;

  function automatic bit on_map(input int r, input int c);
    return (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
  endfunction

  function automatic bit blocked(input int r, input int c);
    if (!on_map(r, c)) return 1'b1;
    return mm[r][c] == 0;
  endfunction

  function automatic bit is_barrier(input int r, input int c);
    if (!on_map(r, c)) return 1'b0;
    return (mm[r][c] >= 2) && (mm[r][c] <= 4);
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      int ld, rd;
      ld = (m_dir + 1) % 4;
      rd = (m_dir + 3) % 4;
      check("cmd_ready", int'(bus.cmd_ready), m_ready);
      check("done", int'(bus.done), m_done);
      if (m_done != 0) check("err", int'(bus.err), m_err);
      check("robo_row", int'(robo_row), m_row);
      check("robo_col", int'(robo_col), m_col);
      check("robo_dir", int'(robo_dir), m_dir);
      check("head_out", int'(head_out), int'(blocked(m_row + dr[m_dir], m_col + dc[m_dir])));
      check("left_out", int'(left_out), int'(blocked(m_row + dr[ld], m_col + dc[ld])));
      check("right_out", int'(right_out), int'(blocked(m_row + dr[rd], m_col + dc[rd])));
      check("under_out", int'(under_out), int'(mm[m_row][m_col] == 7));
      check("barrier_out", int'(barrier_out),
            int'(is_barrier(m_row + dr[m_dir], m_col + dc[m_dir])));
    end
  end

  // ---------------------------------------------------------------------
  // Driver: issues one command and advances the model with it.
  //   lit_lat / lit_err are hand-computed latency and err for this command.
  //   hold keeps cmd_valid high (with a different op) into EXEC.
  // ---------------------------------------------------------------------
  task automatic issue(input logic [1:0] op, input int lit_lat, input int lit_err,
                       input bit hold);
    int ar, ac, p_lat, p_err;
    @(negedge clock);
    ar    = m_row + dr[m_dir];
    ac    = m_col + dc[m_dir];
    p_lat = 1;
    p_err = 0;
    case (op)
      OP_MOVE:   if (blocked(ar, ac) || is_barrier(ar, ac)) p_err = 1;
      OP_REMOVE: if (is_barrier(ar, ac)) p_lat = REMOVE_CYCLES + 1; else p_err = 1;
      default:   p_err = 0;
    endcase
    check("pred_latency", p_lat, lit_lat);
    check("pred_err", p_err, lit_err);

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    @(posedge clock);
    #1;
    if (hold && p_lat > 1) bus.cmd_op = OP_MOVE;
    else begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = ~op;
    end
    m_ready = 0;
    case (op)
      OP_MOVE:  if (p_err == 0) begin m_row = ar; m_col = ac; end
      OP_LEFT:  m_dir = (m_dir + 1) % 4;
      OP_RIGHT: m_dir = (m_dir + 3) % 4;
      default:  ;
    endcase
    for (int k = 1; k < p_lat; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) bus.cmd_valid = 1'b0;
      if (k == p_lat - 1) mm[ar][ac] = mm[ar][ac] - 1;
    end
    m_done = 1;
    m_err  = p_err;
    @(posedge clock);
    #1;
    m_done  = 0;
    m_err   = 0;
    m_ready = 1;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    // Map: row 9 and column 19 are corridors; BLACK at (9,5); codes 5/6 at
    // (9,7)/(9,8); B9 at (0,18) with PATH beyond it; B6 at (1,18).
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mm[r][c] = 0;
    for (int c = 0; c < COLS; c++) mm[9][c] = 1;
    for (int r = 0; r < ROWS; r++) mm[r][19] = 1;
    mm[9][5]  = 7;
    mm[9][7]  = 5;
    mm[9][8]  = 6;
    mm[0][18] = 4;
    mm[0][17] = 1;
    mm[1][18] = 3;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        dut.cell_map[r][c] <= 3'(mm[r][c]);

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    reset         = 1'b1;
    m_row   = START_ROW;
    m_col   = START_COL;
    m_dir   = 0;
    m_ready = 1;
    m_done  = 0;
    m_err   = 0;
    cmp_en  = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_row", int'(robo_row), 9);
    check("rst_col", int'(robo_col), 0);
    check("rst_dir", int'(robo_dir), 0);
    check("rst_ready", int'(bus.cmd_ready), 1);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);

    // Move into the wall north of the start cell
    issue(OP_MOVE, 1, 1, 1'b0);
    check("wall_row", int'(robo_row), 9);

    // Turns
    issue(OP_LEFT, 1, 0, 1'b0);  check("tl1_dir", int'(robo_dir), 1);
    issue(OP_LEFT, 1, 0, 1'b0);  check("tl2_dir", int'(robo_dir), 2);
    issue(OP_LEFT, 1, 0, 1'b0);  check("tl3_dir", int'(robo_dir), 3);
    issue(OP_LEFT, 1, 0, 1'b0);  check("tl4_dir", int'(robo_dir), 0);
    issue(OP_RIGHT, 1, 0, 1'b0); check("tr_dir", int'(robo_dir), 3);

    // Run east along row 9, then bump the east edge
    for (int i = 0; i < COLS - 1; i++) issue(OP_MOVE, 1, 0, 1'b0);
    check("east_col", int'(robo_col), 19);
    issue(OP_MOVE, 1, 1, 1'b0);
    check("east_edge_col", int'(robo_col), 19);
    check("east_edge_head", int'(head_out), 1);

    // Run north along column 19, then bump the north edge
    issue(OP_LEFT, 1, 0, 1'b0);
    for (int i = 0; i < ROWS - 1; i++) issue(OP_MOVE, 1, 0, 1'b0);
    check("north_row", int'(robo_row), 0);
    issue(OP_MOVE, 1, 1, 1'b0);
    check("north_edge_row", int'(robo_row), 0);
    check("north_edge_head", int'(head_out), 1);

    // Face the B9, try to drive into it, then strip it level by level
    issue(OP_LEFT, 1, 0, 1'b0);
    check("b9_barrier", int'(barrier_out), 1);
    issue(OP_MOVE, 1, 1, 1'b0);
    issue(OP_REMOVE, 4, 0, 1'b1); check("rm1_cell", int'(dut.cell_map[0][18]), 3);
    issue(OP_REMOVE, 4, 0, 1'b1); check("rm2_cell", int'(dut.cell_map[0][18]), 2);
    issue(OP_REMOVE, 4, 0, 1'b1); check("rm3_cell", int'(dut.cell_map[0][18]), 1);
    check("rm3_barrier", int'(barrier_out), 0);
    issue(OP_MOVE, 1, 0, 1'b0);
    check("after_rm_col", int'(robo_col), 18);

    // Remove with plain PATH ahead is rejected immediately
    issue(OP_REMOVE, 1, 1, 1'b0);
    check("rm_path_cell", int'(dut.cell_map[0][17]), 1);

    // Face the B6 to the south; moving into it is rejected
    issue(OP_LEFT, 1, 0, 1'b0);
    issue(OP_MOVE, 1, 1, 1'b0);

    // Reset in the middle of a remove aborts it
    @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_REMOVE;
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    m_ready = 0;
    @(posedge clock);
    #1;
    reset   = 1'b1;
    m_row   = START_ROW;
    m_col   = START_COL;
    m_dir   = 0;
    m_ready = 1;
    m_done  = 0;
    m_err   = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("abort_cell", int'(dut.cell_map[1][18]), 3);
    check("abort_row", int'(robo_row), 9);
    check("abort_col", int'(robo_col), 0);
    check("abort_dir", int'(robo_dir), 0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
